// File: rtl/dbus_pkg.sv
// Shared definitions for the CPU/DMA data-bus arbiter: owner encoding,
// default limits, bus widths and a counter-width helper.
package dbus_pkg;

   typedef enum logic {
      S_CPU = 1'b0,
      S_DMA = 1'b1
   } owner_t;

   localparam int DEF_MAX_WAIT  = 4;
   localparam int DEF_MAX_BURST = 8;
   localparam int BUS_AW        = 32;
   localparam int BUS_DW        = 32;

   // Bits needed to count 0..max-1, never less than one bit.
   function automatic int cnt_width(input int max);
      return (max > 1) ? $clog2(max) : 1;
   endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundles the CPU port, DMA port and shared slave path of the data bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dbus_arbiter_if
   import dbus_pkg::*;
#(
   parameter int AW = BUS_AW,
   parameter int DW = BUS_DW
) ();

   logic          cpu_rd;
   logic          cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;

   logic          dma_req;
   logic          dma_wr;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;
   logic [DW-1:0] dma_rdata;

   logic          s_rd;
   logic          s_wr;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [DW-1:0] s_rdata;

   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_wr, dma_addr, dma_wdata,
      output dma_gnt, dma_rdata,
      output s_rd, s_wr, s_addr, s_wdata,
      input  s_rdata
   );

   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_wr, dma_addr, dma_wdata,
      input  dma_gnt, dma_rdata,
      input  s_rd, s_wr, s_addr, s_wdata,
      output s_rdata
   );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; tc flags the last value MAX-1.
module arb_sat_counter
   import dbus_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic tc
);

   localparam int W = cnt_width(MAX);
   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] count;

   // Count up on inc, hold at MAX-1, clear has priority over inc.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && !tc)
         count <= count + 1'b1;
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: the single-cycle CPU has priority, the DMA is
// protected by a starvation counter. Define DBUS_DMA_BURST_EN to let the DMA
// keep the bus for up to MAX_BURST beats while the CPU waits; otherwise the
// DMA hands back after every beat the CPU is waiting on.
module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter int AW        = BUS_AW,
   parameter int DW        = BUS_DW,
   parameter int MAX_WAIT  = DEF_MAX_WAIT,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic          clk,
   input  logic          reset,
   dbus_arbiter_if.slave bus
);

   if (MAX_WAIT < 1 || MAX_BURST < 1) begin : g_bad_param
      $error("dbus_arbiter: MAX_WAIT and MAX_BURST must be at least 1");
   end

   owner_t        owner;
   owner_t        owner_nxt;
   logic          cpu_req;
   logic          wait_inc;
   logic          wait_clr;
   logic          wait_tc;
   logic          rd_mux;
   logic          wr_mux;
   logic          stall;
   logic          gnt;
   logic [AW-1:0] addr_mux;
   logic [DW-1:0] wdata_mux;
`ifdef DBUS_DMA_BURST_EN
   logic          beat_inc;
   logic          beat_clr;
   logic          beat_tc;
`endif

   assign cpu_req = bus.cpu_rd | bus.cpu_wr;

   arb_sat_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (wait_clr),
      .inc   (wait_inc),
      .tc    (wait_tc)
   );

`ifdef DBUS_DMA_BURST_EN
   arb_sat_counter #(.MAX(MAX_BURST)) u_beat_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (beat_clr),
      .inc   (beat_inc),
      .tc    (beat_tc)
   );
`endif

   // Owner register; the grant decision lands on the rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         owner <= S_CPU;
      else
         owner <= owner_nxt;
   end

   // Next owner, counter control and the slave-side mux; reset kills strobes at once.
   always_comb begin
      owner_nxt = owner;
      wait_inc  = 1'b0;
      wait_clr  = 1'b0;
`ifdef DBUS_DMA_BURST_EN
      beat_inc  = 1'b0;
      beat_clr  = 1'b0;
`endif
      rd_mux    = bus.cpu_rd;
      wr_mux    = bus.cpu_wr;
      addr_mux  = bus.cpu_addr;
      wdata_mux = bus.cpu_wdata;
      stall     = 1'b0;
      gnt       = 1'b0;

      if (owner == S_CPU) begin
`ifdef DBUS_DMA_BURST_EN
         beat_clr = 1'b1;
`endif
         if (bus.dma_req && (!cpu_req || wait_tc)) begin
            owner_nxt = S_DMA;
            wait_clr  = 1'b1;
         end else if (bus.dma_req) begin
            wait_inc  = 1'b1;
         end else begin
            wait_clr  = 1'b1;
         end
      end else begin
         wait_clr  = 1'b1;
         gnt       = bus.dma_req;
         stall     = cpu_req;
         rd_mux    = bus.dma_req & ~bus.dma_wr;
         wr_mux    = bus.dma_req &  bus.dma_wr;
         addr_mux  = bus.dma_addr;
         wdata_mux = bus.dma_wdata;
`ifdef DBUS_DMA_BURST_EN
         beat_inc  = bus.dma_req & cpu_req;
         if (!bus.dma_req || (cpu_req && beat_tc))
            owner_nxt = S_CPU;
`else
         if (!bus.dma_req || cpu_req)
            owner_nxt = S_CPU;
`endif
      end

      if (reset) begin
         rd_mux = 1'b0;
         wr_mux = 1'b0;
         stall  = 1'b0;
         gnt    = 1'b0;
      end
   end

   assign bus.s_rd      = rd_mux;
   assign bus.s_wr      = wr_mux;
   assign bus.s_addr    = addr_mux;
   assign bus.s_wdata   = wdata_mux;
   assign bus.cpu_stall = stall;
   assign bus.dma_gnt   = gnt;
   assign bus.cpu_rdata = bus.s_rdata;
   assign bus.dma_rdata = bus.s_rdata;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: directed scenarios then random traffic,
// checked against a cycle-level model of the arbitration rules.
module tb_dbus_arbiter;
   import dbus_pkg::*;

   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int MAX_WAIT  = 4;
   localparam int MAX_BURST = 8;
`ifdef DBUS_DMA_BURST_EN
   localparam bit BURST_EN    = 1'b1;
   localparam int STALL_LIMIT = MAX_BURST;
`else
   localparam bit BURST_EN    = 1'b0;
   localparam int STALL_LIMIT = 1;
`endif

   typedef struct {
      int          step;
      logic        rst;
      logic        s_rd;
      logic        s_wr;
      logic [31:0] s_addr;
      logic [31:0] s_wdata;
      logic        stall;
      logic        gnt;
      logic        chk_cpu_rdata;
      logic        chk_dma_rdata;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   stepNo = 0;
   exp_t expQ[$];

   bit   dmaOwns = 1'b0;
   int   denied  = 0;
   int   beats   = 0;

   always #5 clk = ~clk;

   dbus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dbus_arbiter #(
      .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Drive one cycle of inputs after the edge, push what that cycle must show,
   // then advance the model to the owner expected after the next edge.
   task automatic applyStimulus(input bit rst, input bit crd, input bit cwr,
                                input logic [31:0] caddr, input logic [31:0] cwdata,
                                input bit dreq, input bit dwr,
                                input logic [31:0] daddr, input logic [31:0] dwdata,
                                input logic [31:0] srdata);
      exp_t e;
      bit   cpuReq;
      @(posedge clk);
      #1;
      reset         = rst;
      bus.cpu_rd    = crd;
      bus.cpu_wr    = cwr;
      bus.cpu_addr  = caddr;
      bus.cpu_wdata = cwdata;
      bus.dma_req   = dreq;
      bus.dma_wr    = dwr;
      bus.dma_addr  = daddr;
      bus.dma_wdata = dwdata;
      bus.s_rdata   = srdata;
      cpuReq = crd | cwr;
      stepNo++;
      e.step = stepNo;
      e.rst  = rst;
      e.rdata = srdata;
      e.chk_cpu_rdata = 1'b0;
      e.chk_dma_rdata = 1'b0;
      if (rst) begin
         e.s_rd = 1'b0; e.s_wr = 1'b0; e.stall = 1'b0; e.gnt = 1'b0;
         e.s_addr = caddr; e.s_wdata = cwdata;
         dmaOwns = 1'b0; denied = 0; beats = 0;
      end else if (!dmaOwns) begin
         e.s_rd = crd; e.s_wr = cwr; e.s_addr = caddr; e.s_wdata = cwdata;
         e.stall = 1'b0; e.gnt = 1'b0;
         e.chk_cpu_rdata = crd;
         if (dreq && (!cpuReq || denied + 1 >= MAX_WAIT)) begin
            dmaOwns = 1'b1; denied = 0; beats = 0;
         end else if (dreq) begin
            denied++;
         end else begin
            denied = 0;
         end
      end else begin
         e.gnt = dreq; e.stall = cpuReq;
         e.s_rd = dreq & !dwr; e.s_wr = dreq & dwr;
         e.s_addr = daddr; e.s_wdata = dwdata;
         e.chk_dma_rdata = dreq & !dwr;
         if (!dreq) begin
            dmaOwns = 1'b0;
         end else if (cpuReq) begin
            beats++;
            if (!BURST_EN || beats >= MAX_BURST) begin
               dmaOwns = 1'b0; denied = 0;
            end
         end
      end
      expQ.push_back(e);
   endtask

   task automatic cmpVal(input string name, input int step,
                         input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s step=%0d got=%h want=%h", name, step, act, want);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmpVal("s_rd",      e.step, 32'(bus.s_rd),      32'(e.s_rd));
      cmpVal("s_wr",      e.step, 32'(bus.s_wr),      32'(e.s_wr));
      cmpVal("cpu_stall", e.step, 32'(bus.cpu_stall), 32'(e.stall));
      cmpVal("dma_gnt",   e.step, 32'(bus.dma_gnt),   32'(e.gnt));
      if (!e.rst && (e.s_rd || e.s_wr)) begin
         cmpVal("s_addr",  e.step, bus.s_addr,  e.s_addr);
         cmpVal("s_wdata", e.step, bus.s_wdata, e.s_wdata);
      end
      if (e.chk_cpu_rdata) cmpVal("cpu_rdata", e.step, bus.cpu_rdata, e.rdata);
      if (e.chk_dma_rdata) cmpVal("dma_rdata", e.step, bus.dma_rdata, e.rdata);
   endtask

   // Monitor: pop one expectation per cycle mid-cycle, plus stall-run and
   // DMA-latency bounds taken straight from the observed outputs.
   initial begin : monitor
      int stallRun;
      int deniedRun;
      exp_t e;
      stallRun  = 0;
      deniedRun = 0;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
            if (bus.cpu_stall) begin
               stallRun++;
            end else if (stallRun > 0) begin
               total++;
               if (stallRun > STALL_LIMIT) begin
                  bad++;
                  $display("[TB] FAIL stall_run step=%0d got=%0d want<=%0d",
                           e.step, stallRun, STALL_LIMIT);
               end
               stallRun = 0;
            end
            if (reset || !bus.dma_req) begin
               deniedRun = 0;
            end else if (!bus.dma_gnt) begin
               deniedRun++;
            end else if (deniedRun > 0) begin
               total++;
               if (deniedRun > MAX_WAIT) begin
                  bad++;
                  $display("[TB] FAIL dma_latency step=%0d got=%0d want<=%0d",
                           e.step, deniedRun, MAX_WAIT);
               end
               deniedRun = 0;
            end
         end
      end
   end

   // Stimulus: directed scenarios first, then random traffic with phases.
   initial begin : stimulus
      int pCpu;
      int pDma;
      reset = 1'b1;
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
      bus.s_rdata = '0;

      // Reset with both masters requesting: nothing may reach the slave.
      repeat (2) applyStimulus(1, 1, 0, 32'h100, 32'h0, 1, 1, 32'h200, 32'h55, 32'h77);

      // DMA read with the CPU idle.
      repeat (2) applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h40000010, 32'h0, 32'h1234);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);

      // Continuous contention: wait bound then burst bound, twice over.
      for (int i = 0; i < 26; i++)
         applyStimulus(0, 1, 0, 32'h1000 + 32'(i), 32'h0, 1, 0, 32'h2000 + 32'(i),
                       32'h0, 32'hA000 + 32'(i));
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);

      // DMA drops its request while the CPU waits; the CPU store follows.
      repeat (2) applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h300, 32'h11, 32'h0);
      applyStimulus(0, 0, 1, 32'h500, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 32'h0);
      applyStimulus(0, 0, 1, 32'h500, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 32'h0);

      // Reset in the middle of a DMA write burst, then a plain CPU load.
      for (int i = 0; i < 7; i++)
         applyStimulus(0, 1, 0, 32'h600, 32'h0, 1, 1, 32'h700 + 32'(i), 32'hB0 + 32'(i), 32'h9);
      repeat (2) applyStimulus(1, 1, 0, 32'h600, 32'h0, 1, 1, 32'h710, 32'hC0, 32'h9);
      applyStimulus(0, 1, 0, 32'h600, 32'h0, 0, 0, 32'h0, 32'h0, 32'hCAFE);

      // Random traffic in phases of varying request density.
      for (int blk = 0; blk < 150; blk++) begin
         pCpu = int'($urandom_range(0, 100));
         pDma = int'($urandom_range(0, 100));
         for (int i = 0; i < 16; i++) begin
            bit crd, cwr, dreq, rst;
            crd  = ($urandom_range(0, 99) < pCpu);
            cwr  = !crd && ($urandom_range(0, 99) < pCpu / 2);
            dreq = ($urandom_range(0, 99) < pDma);
            rst  = ($urandom_range(0, 999) < 3);
            applyStimulus(rst, crd, cwr, $urandom, $urandom, dreq, 1'($urandom),
                          $urandom, $urandom, $urandom);
         end
      end

      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain got=%0d want=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the CPU data bus. It shares the single data-side slave path (DataMemory, Peripheral, UART, all decoded downstream on one address) between the single-cycle CPU load/store port and a DMA master. The CPU normally has priority. The DMA is guaranteed forward progress by a starvation counter and bounded bursts. When the CPU loses the bus it receives a stall that freezes PC and register-file write-back for that cycle.

## Interface
Parameters:
- AW, 32: address width
- DW, 32: data width
- MAX_WAIT, 4: consecutive contested cycles the DMA may be denied before a forced handover (≥1)
- MAX_BURST, 8: maximum DMA beats while the CPU is waiting (≥1)

Ports:
- clk  in  1  CPU clock
- reset  in  1  reset, asynchronous, active-high
- cpu_rd  in  1  CPU load (MemRd)
- cpu_wr  in  1  CPU store (MemWr)
- cpu_addr  in  AW  ALU result address
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data to write-back mux
- cpu_stall  out  1  CPU must hold PC and suppress RegWr, MemWr, MemRd effects this cycle
- dma_req  in  1  DMA beat request
- dma_wr  in  1  1 = write, 0 = read
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_gnt  out  1  beat accepted at the next rising edge
- dma_rdata  out  DW  read data, valid when dma_gnt & ~dma_wr
- s_rd  out  1  slave read strobe
- s_wr  out  1  slave write strobe
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_rdata  in  DW  ORed slave read data, combinational

## Operation
- cpu_req = cpu_rd | cpu_wr.
- Owner register with two states: S_CPU and S_DMA. Slave-side mux selects on owner. The non-owner's strobes never reach s_rd/s_wr.
- cpu_rdata and dma_rdata are both driven from s_rdata. Each is meaningful only to the current owner.

S_CPU:
- cpu_stall = 0, dma_gnt = 0.
- Go to S_DMA when dma_req & (~cpu_req | wait_cnt == MAX_WAIT-1).
- wait_cnt increments when dma_req & cpu_req and no transition occurs. It clears when dma_req is low or on entry to S_DMA. It saturates and never wraps.

S_DMA:
- dma_gnt = dma_req.
- cpu_stall = cpu_req.
- s_* is driven from dma_*; a beat completes on each edge with dma_gnt.
- beat_cnt increments per completed beat while cpu_req. It clears on entry to S_DMA.
- Return to S_CPU when ~dma_req, or when cpu_req & beat_cnt == MAX_BURST-1 & a beat completes.
- If the CPU is idle, the DMA keeps the bus indefinitely.

Simultaneous events:
- dma_req and cpu_req both rise in S_CPU: the CPU wins; the DMA waits.
- dma_req drops in the same cycle the CPU requests: return to S_CPU at that edge; the CPU stalls for exactly that one cycle.

While reset is high:
- s_rd = s_wr = 0, cpu_stall = 0, dma_gnt = 0.
- owner = S_CPU; wait_cnt and beat_cnt = 0.
- Reset mid-burst aborts the burst without any partial-beat strobe after assertion.

## Timing
- Zero-latency data path: strobes, address, and read data are combinational through the owner mux, consistent with the single-cycle CPU.
- Owner changes only on the rising clk edge. The grant decision therefore takes effect one cycle after the inputs that cause it.
- A contested DMA request is granted at most MAX_WAIT cycles after assertion.
- A waiting CPU stalls at most MAX_BURST consecutive cycles per handover.
- All outputs have a purely combinational dependency on owner and inputs. There is no path from dma_* inputs to cpu_stall except via owner.

## Configuration
- DBUS_DMA_BURST_EN defined: burst behaviour as above, bounded by MAX_BURST.
- DBUS_DMA_BURST_EN undefined:
  - beat_cnt is removed and MAX_BURST is ignored.
  - S_DMA returns to S_CPU after every completed beat when cpu_req is high.
  - Each handover costs the CPU exactly one stall cycle.

## Structure
- Shared package dbus_pkg:
  - owner/state enum (S_CPU = 1'b0, S_DMA = 1'b1)
  - default MAX_WAIT and MAX_BURST constants
  - bus-width localparams
- One sub-module, arb_sat_counter: a parameterised saturating up-counter with clear, inc, and terminal-count output. It is instantiated for wait_cnt and, under DBUS_DMA_BURST_EN, for beat_cnt.

## Test plan
- DMA read with the CPU idle. dma_req=1, dma_addr=0x40000010, s_rdata=0x1234 → next cycle owner=S_DMA, dma_gnt=1, s_rd=1, s_addr=0x40000010, dma_rdata=0x1234, cpu_stall=0.
- Contested request, MAX_WAIT=4. cpu_rd and dma_req held high → DMA denied 3 cycles, owner=S_DMA on the 4th edge, cpu_stall=1 in that cycle.
- Burst bound, MAX_BURST=8, macro defined. Both requesting continuously → exactly 8 consecutive dma_gnt cycles with cpu_stall=1, then 1+ CPU cycles.
- Same stimulus with the macro undefined → alternation of 1 DMA grant and CPU cycles. cpu_stall is never high for 2 consecutive cycles.
- dma_req drops while the CPU waits → owner=S_CPU at that edge, cpu_stall=0 next cycle, cpu_wr reaches s_wr with cpu_wdata=0xDEADBEEF.
- Async reset asserted mid-burst → s_wr, s_rd, dma_gnt, and cpu_stall go to 0 immediately. After release, owner=S_CPU and the first cpu_rd passes straight through.
